// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the Gray-code step sequencer.
package gray_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Sized for the widest legal counter; callers take the low WIDTH bits.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// Binary step counter with registered natural code and derived Gray code.
module gray_step_core
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray
);

  logic [15:0] gray_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary <= '0;
    end else if (clr) begin
      binary <= '0;
    end else if (cen) begin
      binary <= binary + WIDTH'(1);
    end
  end

  // Decoded only from the register, so gray changes once per clock.
  assign gray_full = bin2gray(16'(binary));
  assign gray      = gray_full[WIDTH-1:0];

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer: steps the Gray counter a programmed number of times.
module gray_seq_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic             cmd_mode,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             step,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [WIDTH:0] FULL_LEN = (WIDTH+1)'(1) << WIDTH;

  state_t         state, state_nxt;
  logic [WIDTH:0] remaining;
  logic [WIDTH:0] len_q;
  logic           mode_q;
  logic           accept;
  logic           start_idle;
  logic           stop_run;
  logic           clear_any;
  logic           start_run;
  logic           inc;
  logic           last;
  logic           cen;
  logic           clr;
  logic [WIDTH:0] len_ext;

  assign accept     = cmd_valid && cmd_ready;
  assign start_idle = accept && (state == IDLE) && (cmd_op == OP_START);
  assign stop_run   = accept && (state == RUN)  && (cmd_op == OP_STOP);
  assign start_run  = accept && (state == RUN)  && (cmd_op == OP_START);
  assign clear_any  = accept && (cmd_op == OP_CLEAR);
  assign inc        = (state == RUN) && !stop_run && !clear_any;
  assign last       = inc && (remaining == (WIDTH+1)'(1));
  assign len_ext    = (cmd_len == '0) ? FULL_LEN : {1'b0, cmd_len};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_idle) state_nxt = RUN;
      RUN: begin
        if (stop_run || clear_any)  state_nxt = IDLE;
        else if (last && !mode_q)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state != DONE);
    busy      = (state == RUN);
    cen       = inc;
    clr       = clear_any;
  end

  // Continuous mode reloads from the latched length so periods abut.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
    end else if (start_idle) begin
      remaining <= len_ext;
      len_q     <= len_ext;
      mode_q    <= cmd_mode;
    end else if (inc) begin
      if (last) remaining <= mode_q ? len_q : remaining;
      else      remaining <= remaining - (WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step    <= 1'b0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      step    <= inc;
      done    <= last;
      cmd_err <= start_run;
    end
  end

  gray_step_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .clr    (clr),
    .binary (binary),
    .gray   (gray)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: expected steps queued at command time, popped on step.
module tb_gray_seq_ctrl;

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_STOP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gry;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = C_NOP;
  logic [3:0] cmd_len = '0;
  logic       cmd_mode = 1'b0;
  logic [3:0] binary;
  logic [3:0] gray;
  logic       busy;
  logic       step;
  logic       done;
  logic       cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_err = 0;
  int n_ready_low = 0;
  exp_t exp_q[$];

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
    .binary(binary), .gray(gray), .busy(busy), .step(step), .done(done),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard consumer: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cmd_ready === 1'b0) n_ready_low++;
    if (done === 1'b1) n_done++;
    if (cmd_err === 1'b1) n_err++;
    if (step === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL spurious_step: got step at binary=%0d, expected no step", binary);
      end else begin
        e = exp_q.pop_front();
        if (binary !== e.bin || gray !== e.gry || done !== e.dn) begin
          n_errors++;
          $display("FAIL step_value: got bin=%0d gray=%b done=%b, expected bin=%0d gray=%b done=%b",
                   binary, gray, done, e.bin, e.gry, e.dn);
        end
      end
    end else if (rst_n === 1'b1 && done === 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_without_step: got done=1 step=%b, expected done only with step", step);
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] len, input logic mode);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_mode = mode;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = C_NOP;
  endtask

  task automatic push_run(input int start, input int n, input int len, input bit mode);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.bin = 4'((start + i) % 16);
      e.gry = to_gray(e.bin);
      e.dn  = mode ? ((i % len) == 0) : (i == len);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = C_START; cmd_len = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_binary", binary, 0);
    check_val("reset_gray", gray, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_ready", cmd_ready, 1);
    check_val("reset_step_done_err", {step, done, cmd_err}, 0);
    cmd_valid = 1'b0; cmd_op = C_NOP;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_no_run", busy, 0);
  endtask

  task automatic test_oneshot();
    logic [3:0] gtab [5];
    exp_t e;
    gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    for (int i = 0; i < 5; i++) begin
      e.bin = 4'(i + 1); e.gry = gtab[i]; e.dn = (i == 4);
      exp_q.push_back(e);
    end
    n_done = 0; n_ready_low = 0;
    send_cmd(C_START, 4'd5, 1'b0);
    @(negedge clk);
    check_val("oneshot_busy", busy, 1);
    repeat (8) @(negedge clk);
    check_val("oneshot_queue", exp_q.size(), 0);
    check_val("oneshot_done_count", n_done, 1);
    check_val("oneshot_ready_low", n_ready_low, 1);
    check_val("oneshot_busy_end", busy, 0);
    check_val("oneshot_binary", binary, 5);
  endtask

  task automatic test_len_zero();
    send_cmd(C_CLEAR, 4'd0, 1'b0);
    @(negedge clk);
    check_val("idle_clear", binary, 0);
    push_run(0, 16, 16, 1'b0);
    n_done = 0;
    send_cmd(C_START, 4'd0, 1'b0);
    repeat (20) @(negedge clk);
    check_val("len0_queue", exp_q.size(), 0);
    check_val("len0_done_count", n_done, 1);
    check_val("len0_wrap_gray", gray, 0);
  endtask

  task automatic test_continuous_stop();
    send_cmd(C_CLEAR, 4'd0, 1'b0);
    push_run(0, 7, 3, 1'b1);
    n_done = 0;
    send_cmd(C_START, 4'd3, 1'b1);
    repeat (6) @(posedge clk);
    send_cmd(C_STOP, 4'd0, 1'b0);
    @(negedge clk);
    check_val("stop_busy", busy, 0);
    check_val("stop_binary", binary, 7);
    check_val("stop_gray", gray, 4'b0100);
    repeat (4) @(negedge clk);
    check_val("stop_hold", binary, 7);
    check_val("cont_done_count", n_done, 2);
    check_val("cont_queue", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    send_cmd(C_CLEAR, 4'd0, 1'b0);
    push_run(0, 4, 4, 1'b0);
    n_done = 0; n_err = 0;
    send_cmd(C_START, 4'd4, 1'b0);
    send_cmd(C_START, 4'd9, 1'b1);
    repeat (8) @(negedge clk);
    check_val("start_in_run_err", n_err, 1);
    check_val("start_in_run_done", n_done, 1);
    check_val("start_in_run_binary", binary, 4);
    check_val("start_in_run_queue", exp_q.size(), 0);
  endtask

  task automatic test_clear_run();
    push_run(4, 3, 8, 1'b0);
    n_done = 0;
    send_cmd(C_START, 4'd8, 1'b0);
    repeat (2) @(posedge clk);
    send_cmd(C_CLEAR, 4'd0, 1'b0);
    @(negedge clk);
    check_val("clear_binary", binary, 0);
    check_val("clear_busy", busy, 0);
    repeat (4) @(negedge clk);
    check_val("clear_hold", binary, 0);
    check_val("clear_done_count", n_done, 0);
    check_val("clear_queue", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_run();
    push_run(0, 9, 12, 1'b0);
    send_cmd(C_START, 4'd12, 1'b0);
    repeat (8) @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_binary", binary, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_ready", cmd_ready, 1);
    check_val("midrst_pulses", {step, done, cmd_err}, 0);
    check_val("midrst_queue", exp_q.size(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_run(0, 2, 2, 1'b0);
    n_done = 0;
    send_cmd(C_START, 4'd2, 1'b0);
    repeat (5) @(negedge clk);
    check_val("after_rst_binary", binary, 2);
    check_val("after_rst_done", n_done, 1);
    check_val("after_rst_queue", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_len_zero();
    test_continuous_stop();
    test_back_to_back();
    test_clear_run();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Command-driven sequencer for the team's WIDTH-bit Gray-code counter. The block accepts START/STOP/CLEAR commands over a valid/ready handshake and steps the counter a programmed number of times. It runs either one-shot or continuously and reports every step and every completed run. It sits between a host/control FSM and any consumer of Gray-coded positions, such as pointer or position encoders.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 CLEAR.
- cmd_len  in  WIDTH  step count for START; 0 means 2^WIDTH steps.
- cmd_mode  in  1  0 one-shot, 1 continuous (period = len).
- binary  out  WIDTH  natural-code count, registered.
- gray  out  WIDTH  Gray code of binary: binary ^ (binary >> 1).
- busy  out  1  high while in RUN.
- step  out  1  registered pulse, high the cycle after each increment.
- done  out  1  registered pulse, high the cycle after the last step of a period.
- cmd_err  out  1  registered pulse, high the cycle after an illegal command is accepted.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready = (state != DONE).
- IDLE:
  - START latches len and mode, sets remaining = len (0 maps to 2^WIDTH), and goes to RUN. The counter is not cleared.
  - STOP: no effect.
  - CLEAR: binary is set to 0.
- RUN, on each cycle with no STOP/CLEAR accepted:
  - binary <= binary + 1, mod 2^WIDTH, so 2^WIDTH-1 wraps to 0.
  - remaining decrements.
  - When remaining == 1 at the increment:
    - one-shot: go to DONE.
    - continuous: reload remaining from the latched len and stay in RUN.
  - done pulses in both modes.
- RUN + STOP: no increment that cycle; go to IDLE; binary holds; done is not pulsed.
- RUN + CLEAR: binary <= 0; go to IDLE; no step.
- RUN + START: cmd_err pulses; run continues unchanged, including this cycle's increment.
- DONE: lasts exactly 1 cycle with cmd_ready = 0, then returns to IDLE.
- Widths: remaining is WIDTH+1 bits so it can hold 2^WIDTH. gray is combinational from the binary register, so it is glitch-free relative to clk.

## Timing
- Reset (rst_n low at a clock edge): binary = 0, gray = 0, busy = 0, step = 0, done = 0, cmd_err = 0, state = IDLE, cmd_ready = 1. Reset overrides any command in the same cycle, and a reset mid-run aborts the run.
- START accepted at edge n:
  - busy is high from n.
  - Increments occur at edges n+1 .. n+L.
  - step is high in the cycles following edges n+1 .. n+L.
  - done is high in the cycle after edge n+L.
  - One-shot: state is DONE after n+L and IDLE after n+L+1; the next START can be accepted at edge n+L+2.
- Continuous mode: done pulses every L cycles with no gap between periods.
- STOP or CLEAR accepted at edge m: the last increment is at edge m-1, and busy is low after m.

## Structure
- Shared package gray_ctrl_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - opcode constants OP_NOP, OP_START, OP_STOP, OP_CLEAR;
  - a bin2gray function.
- Sub-module gray_step_core (clk, rst_n, cen, clr → binary, gray) holds the counter register and Gray encoding.
- gray_seq_ctrl contains the FSM, the remaining counter and the pulse registers, and drives cen/clr of gray_step_core.

## Test plan
- Reset: hold rst_n low for 2 cycles while cmd_valid=1 and START is presented → binary=0, gray=0, busy=0, cmd_ready=1, no step/done.
- One-shot, WIDTH=4, START len=5 from 0 → gray = 0001, 0011, 0010, 0110, 0111 on 5 consecutive cycles; one done pulse; cmd_ready=0 for exactly 1 cycle; busy low.
- len=0 from binary=0 → 16 steps; gray reaches 1000 at binary=15 and wraps to 0000; done once.
- Continuous, len=3 → done on every 3rd step. STOP accepted at binary=7 → counter holds at 7 (gray 0100), no done, busy drops next cycle.
- START during RUN → one cmd_err pulse, step count unchanged. CLEAR during RUN → binary=0 next cycle, IDLE, no done.
- rst_n low mid-run at binary=9 → all outputs at reset values after that edge; a subsequent START len=2 counts from 0.
